um_pkt_mux2: RTL and testbench

//  2-to-1 packet-level output merger inside UM, immediately upstream of a um2portN output interface.

---
 rtl/um_pkt_mux2.sv | 384 ++++++++++++++++++++++++++++++++++++++
 tb/tb_um_pkt_mux2.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/um_pkt_mux2.sv
// ---------------------------------------------------------------------------
// um_pkt_mux2 -- 2-to-1 packet-level merger feeding a um2portN output port.
//
// Each input stream is buffered in its own data FIFO. Once a packet's
// end strobe arrives, a {valid, word_count} record is committed to that
// input's packet queue. A read FSM grants whole packets round-robin. It
// forwards valid packets and silently drains invalid ones.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   inN_data_wr / inN_data        input N word strobe and 134-bit word
//   inN_data_valid(_wr)           input N packet-end strobe and valid flag
//   out_inN_ready                 input N may start a new packet (registered)
//   out_data_wr / out_data        output word strobe and word
//   out_data_valid(_wr)           output packet-end strobe and valid flag
//   in_port_usedw                 downstream FIFO fill level
//
// Handshake: the upstream may start a packet only while out_inN_ready=1.
// Once started, the packet is accepted word by word without stalls, and
// there is no per-word back-pressure. Downstream flow control acts only at
// packet start: a valid packet starts only while
// in_port_usedw <= USEDW_TH, and it then streams to completion.
//
// Word tag [133:132]: 01 head, 11 middle, 10 tail.
// The FSM states are visible as ws_q (write side, per input) and rs_q (read side).
// ---------------------------------------------------------------------------
module um_pkt_mux2 #(
    parameter int         DATA_DEPTH    = 256,
    parameter int         AW            = 8,
    parameter int         PKTQ_DEPTH    = 8,
    parameter int         MAX_PKT_WORDS = 96,
    parameter logic [7:0] USEDW_TH      = 8'd160
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_data_wr,
    input  logic [133:0] in0_data,
    input  logic         in0_data_valid,
    input  logic         in0_data_valid_wr,
    output logic         out_in0_ready,
    input  logic         in1_data_wr,
    input  logic [133:0] in1_data,
    input  logic         in1_data_valid,
    input  logic         in1_data_valid_wr,
    output logic         out_in1_ready,
    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid,
    output logic         out_data_valid_wr,
    input  logic [7:0]   in_port_usedw
);

    localparam int          QW             = $clog2(PKTQ_DEPTH);
    localparam logic [AW:0] DEPTH_W        = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0] READY_MAX_USED = (AW+1)'(DATA_DEPTH - MAX_PKT_WORDS);
    localparam logic [AW:0] LEN_ONE        = (AW+1)'(1);
    localparam logic [QW:0] PQ_DEPTH_W     = (QW+1)'(PKTQ_DEPTH);

    localparam logic       WS_WAIT_HEAD = 1'b0;
    localparam logic       WS_RECV      = 1'b1;

    localparam logic [1:0] RS_IDLE = 2'd0;
    localparam logic [1:0] RS_SEND = 2'd1;
    localparam logic [1:0] RS_DROP = 2'd2;

    // ---------------- input bundling ----------------
    logic [133:0] in_data [2];
    logic [1:0]   in_wr;
    logic [1:0]   in_vld;
    logic [1:0]   in_vwr;

    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in_wr      = {in1_data_wr, in0_data_wr};
    assign in_vld     = {in1_data_valid, in0_data_valid};
    assign in_vwr     = {in1_data_valid_wr, in0_data_valid_wr};

    // ---------------- storage ----------------
    logic [133:0] data_mem_q [2][DATA_DEPTH];
    logic         pq_vld_q   [2][PKTQ_DEPTH];
    logic [AW:0]  pq_len_q   [2][PKTQ_DEPTH];

    // ---------------- write-side state ----------------
    // Pointers carry one extra bit so that full (diff == DEPTH) and empty
    // (diff == 0) are distinguishable; the address is the low AW bits.
    logic [AW:0]  wr_ptr_q    [2];
    logic [AW:0]  wr_ptr_d    [2];
    logic [AW:0]  start_ptr_q [2];
    logic [AW:0]  start_ptr_d [2];
    logic [AW:0]  wcnt_q      [2];
    logic [AW:0]  wcnt_d      [2];
    logic [1:0]   ws_q;
    logic [1:0]   ws_d;
    logic [1:0]   err_q;
    logic [1:0]   err_d;
    logic [QW:0]  pq_wr_q     [2];
    logic [QW:0]  pq_wr_d     [2];
    logic [1:0]   ready_q;
    logic [1:0]   ready_d;

    logic [1:0]    mem_we;
    logic [AW-1:0] mem_waddr [2];
    logic [1:0]    pq_we;
    logic [QW-1:0] pq_waddr  [2];
    logic [1:0]    pq_wvld;
    logic [AW:0]   pq_wlen   [2];

    // ---------------- read-side state ----------------
    logic [AW:0]  rd_ptr_q [2];
    logic [AW:0]  rd_ptr_d [2];
    logic [QW:0]  pq_rd_q  [2];
    logic [QW:0]  pq_rd_d  [2];
    logic [1:0]   rs_q;
    logic [1:0]   rs_d;
    logic         sel_q;
    logic         sel_d;
    logic         rr_q;
    logic         rr_d;
    logic [AW:0]  remain_q;
    logic [AW:0]  remain_d;
    logic         out_wr_q;
    logic         out_wr_d;
    logic [133:0] out_data_q;
    logic [133:0] out_data_d;
    logic         out_vld_q;
    logic         out_vld_d;
    logic         out_vwr_q;
    logic         out_vwr_d;

    // ---------------- write side ----------------
    logic        w_is_head;
    logic        w_start_new;
    logic        w_accept;
    logic        w_commit;
    logic        w_pq_full;
    logic [AW:0] w_ptr;
    logic [AW:0] w_cnt;
    logic        w_err;
    logic [AW:0] w_pstart;

    always_comb begin
        w_is_head   = 1'b0;
        w_start_new = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_pq_full   = 1'b0;
        w_ptr       = '0;
        w_cnt       = '0;
        w_err       = 1'b0;
        w_pstart    = '0;
        ws_d        = ws_q;
        err_d       = err_q;
        ready_d     = ready_q;
        mem_we      = '0;
        pq_we       = '0;
        pq_wvld     = '0;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i]    = wr_ptr_q[i];
            start_ptr_d[i] = start_ptr_q[i];
            wcnt_d[i]      = wcnt_q[i];
            pq_wr_d[i]     = pq_wr_q[i];
            mem_waddr[i]   = wr_ptr_q[i][AW-1:0];
            pq_waddr[i]    = pq_wr_q[i][QW-1:0];
            pq_wlen[i]     = '0;

            w_is_head   = in_wr[i] && (in_data[i][133:132] == 2'b01);
            // A head while receiving opens a new packet unless it coincides
            // with the end strobe, in which case it is the old packet's tail.
            w_start_new = w_is_head && ((ws_q[i] == WS_WAIT_HEAD) || !in_vwr[i]);
            w_accept    = in_wr[i] && ((ws_q[i] == WS_RECV) || w_is_head);
            w_commit    = in_vwr[i] && ((ws_q[i] == WS_RECV) || w_is_head);
            w_pq_full   = (pq_wr_q[i] - pq_rd_q[i]) == PQ_DEPTH_W;
            w_ptr       = wr_ptr_q[i];
            w_cnt       = wcnt_q[i];
            w_err       = err_q[i];
            w_pstart    = start_ptr_q[i];

            // Packet abandoned by a fresh head: commit what we have as invalid
            // so the reader drains it.
            if ((ws_q[i] == WS_RECV) && w_start_new) begin
                if (!w_pq_full) begin
                    pq_we[i]   = 1'b1;
                    pq_wvld[i] = 1'b0;
                    pq_wlen[i] = w_cnt;
                    pq_wr_d[i] = pq_wr_q[i] + 1'b1;
                end else begin
                    // No record slot: rewind so the orphan words vanish.
                    w_ptr = w_pstart;
                end
            end

            if (w_start_new) begin
                w_pstart = w_ptr;
                w_cnt    = '0;
                w_err    = 1'b0;
            end

            if (w_accept) begin
                if ((w_ptr - rd_ptr_q[i]) == DEPTH_W) begin
                    w_err = 1'b1;
                end else begin
                    mem_we[i]    = 1'b1;
                    mem_waddr[i] = w_ptr[AW-1:0];
                    w_ptr        = w_ptr + 1'b1;
                    w_cnt        = w_cnt + 1'b1;
                end
            end

            if (w_commit) begin
                if (!w_pq_full) begin
                    pq_we[i]   = 1'b1;
                    pq_wvld[i] = in_vld[i] && !w_err;
                    pq_wlen[i] = w_cnt;
                    pq_wr_d[i] = pq_wr_q[i] + 1'b1;
                end else begin
                    w_ptr = w_pstart;
                end
                ws_d[i] = WS_WAIT_HEAD;
                w_cnt   = '0;
                w_err   = 1'b0;
            end else if (w_start_new) begin
                ws_d[i] = WS_RECV;
            end

            wr_ptr_d[i]    = w_ptr;
            start_ptr_d[i] = w_pstart;
            wcnt_d[i]      = w_cnt;
            err_d[i]       = w_err;
            // Room for one worst-case packet and a free record slot.
            ready_d[i]     = ((wr_ptr_q[i] - rd_ptr_q[i]) <= READY_MAX_USED) && !w_pq_full;
        end
    end

    // ---------------- read side ----------------
    logic [1:0]   pq_nempty;
    logic         cand;
    logic         rd_idx;
    logic [133:0] rd_word;
    logic         head_vld;
    logic [AW:0]  head_len;

    always_comb begin
        rs_d        = rs_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        remain_d    = remain_q;
        rd_ptr_d[0] = rd_ptr_q[0];
        rd_ptr_d[1] = rd_ptr_q[1];
        pq_rd_d[0]  = pq_rd_q[0];
        pq_rd_d[1]  = pq_rd_q[1];
        out_wr_d    = 1'b0;
        out_data_d  = '0;
        out_vld_d   = 1'b0;
        out_vwr_d   = 1'b0;

        pq_nempty[0] = pq_wr_q[0] != pq_rd_q[0];
        pq_nempty[1] = pq_wr_q[1] != pq_rd_q[1];
        // Prefer the round-robin input; fall back to the other one.
        cand     = pq_nempty[rr_q] ? rr_q : ~rr_q;
        rd_idx   = (rs_q == RS_IDLE) ? cand : sel_q;
        rd_word  = data_mem_q[rd_idx][rd_ptr_q[rd_idx][AW-1:0]];
        head_vld = pq_vld_q[cand][pq_rd_q[cand][QW-1:0]];
        head_len = pq_len_q[cand][pq_rd_q[cand][QW-1:0]];

        case (rs_q)
            RS_IDLE: begin
                if (pq_nempty[cand]) begin
                    if (!head_vld) begin
                        rs_d     = RS_DROP;
                        sel_d    = cand;
                        rr_d     = ~cand;
                        remain_d = head_len;
                    end else if (in_port_usedw <= USEDW_TH) begin
                        // The grant cycle already reads the first word so
                        // that it appears on the output one cycle later.
                        sel_d          = cand;
                        rr_d           = ~cand;
                        out_wr_d       = 1'b1;
                        out_data_d     = rd_word;
                        rd_ptr_d[cand] = rd_ptr_q[cand] + 1'b1;
                        if (head_len <= LEN_ONE) begin
                            out_vld_d     = 1'b1;
                            out_vwr_d     = 1'b1;
                            pq_rd_d[cand] = pq_rd_q[cand] + 1'b1;
                        end else begin
                            rs_d     = RS_SEND;
                            remain_d = head_len - 1'b1;
                        end
                    end
                end
            end
            RS_SEND: begin
                out_wr_d        = 1'b1;
                out_data_d      = rd_word;
                rd_ptr_d[sel_q] = rd_ptr_q[sel_q] + 1'b1;
                remain_d        = remain_q - 1'b1;
                if (remain_q == LEN_ONE) begin
                    out_vld_d      = 1'b1;
                    out_vwr_d      = 1'b1;
                    pq_rd_d[sel_q] = pq_rd_q[sel_q] + 1'b1;
                    rs_d           = RS_IDLE;
                end
            end
            RS_DROP: begin
                if (remain_q != '0) begin
                    rd_ptr_d[sel_q] = rd_ptr_q[sel_q] + 1'b1;
                    remain_d        = remain_q - 1'b1;
                end
                // Length 0 is possible when the head itself hit a full FIFO.
                if (remain_q <= LEN_ONE) begin
                    pq_rd_d[sel_q] = pq_rd_q[sel_q] + 1'b1;
                    rs_d           = RS_IDLE;
                end
            end
            default: rs_d = RS_IDLE;
        endcase
    end

    // ---------------- storage writes (no reset) ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) begin
                data_mem_q[i][mem_waddr[i]] <= in_data[i];
            end
            if (pq_we[i]) begin
                pq_vld_q[i][pq_waddr[i]] <= pq_wvld[i];
                pq_len_q[i][pq_waddr[i]] <= pq_wlen[i];
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= '0;
                start_ptr_q[i] <= '0;
                wcnt_q[i]      <= '0;
                pq_wr_q[i]     <= '0;
                rd_ptr_q[i]    <= '0;
                pq_rd_q[i]     <= '0;
            end
            ws_q       <= {WS_WAIT_HEAD, WS_WAIT_HEAD};
            err_q      <= '0;
            ready_q    <= '0;
            rs_q       <= RS_IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            remain_q   <= '0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_vwr_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= wr_ptr_d[i];
                start_ptr_q[i] <= start_ptr_d[i];
                wcnt_q[i]      <= wcnt_d[i];
                pq_wr_q[i]     <= pq_wr_d[i];
                rd_ptr_q[i]    <= rd_ptr_d[i];
                pq_rd_q[i]     <= pq_rd_d[i];
            end
            ws_q       <= ws_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            rs_q       <= rs_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            remain_q   <= remain_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_vwr_q  <= out_vwr_d;
        end
    end

    assign out_in0_ready     = ready_q[0];
    assign out_in1_ready     = ready_q[1];
    assign out_data_wr       = out_wr_q;
    assign out_data          = out_data_q;
    assign out_data_valid    = out_vld_q;
    assign out_data_valid_wr = out_vwr_q;

endmodule

// File: tb/tb_um_pkt_mux2.sv
// Bench for um_pkt_mux2: table of single packets, hand-written multi-cycle
// sequences, and an in-order scoreboard of {is_tail, word}.
module tb_um_pkt_mux2;

  localparam int W = 135;

  logic         clk;
  logic         rst_n;
  logic         in0_data_wr, in0_data_valid, in0_data_valid_wr, out_in0_ready;
  logic [133:0] in0_data;
  logic         in1_data_wr, in1_data_valid, in1_data_valid_wr, out_in1_ready;
  logic [133:0] in1_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic [133:0] out_data;
  logic [7:0]   in_port_usedw;

  um_pkt_mux2 dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in0_data_wr       (in0_data_wr),
    .in0_data          (in0_data),
    .in0_data_valid    (in0_data_valid),
    .in0_data_valid_wr (in0_data_valid_wr),
    .out_in0_ready     (out_in0_ready),
    .in1_data_wr       (in1_data_wr),
    .in1_data          (in1_data),
    .in1_data_valid    (in1_data_valid),
    .in1_data_valid_wr (in1_data_valid_wr),
    .out_in1_ready     (out_in1_ready),
    .out_data_wr       (out_data_wr),
    .out_data          (out_data),
    .out_data_valid    (out_data_valid),
    .out_data_valid_wr (out_data_valid_wr),
    .in_port_usedw     (in_port_usedw)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int out_cnt = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (out_data_wr) begin
        checks++;
        out_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word act=%h exp=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[133:0] || out_data_valid_wr !== e[134] || out_data_valid !== e[134]) begin
            failures++;
            $display("FAIL out_word act=%h vwr=%b v=%b exp=%h vwr=%b", out_data,
                     out_data_valid_wr, out_data_valid, e[133:0], e[134]);
          end
        end
      end else begin
        checks++;
        if (out_data_valid_wr !== 1'b0 || out_data_valid !== 1'b0) begin
          failures++;
          $display("FAIL stray_valid act=%b%b exp=00", out_data_valid_wr, out_data_valid);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, expv);
    end
  endtask

  function automatic logic [133:0] make_word(input logic [1:0] tag);
    return {tag, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    in0_data_wr = 0; in0_data = '0; in0_data_valid = 0; in0_data_valid_wr = 0;
    in1_data_wr = 0; in1_data = '0; in1_data_valid = 0; in1_data_valid_wr = 0;
  endtask

  task automatic drive(input int port, input logic wr, input logic [133:0] d,
                       input logic vwr, input logic vld);
    if (port == 0) begin
      in0_data_wr = wr; in0_data = d; in0_data_valid_wr = vwr; in0_data_valid = vld;
    end else begin
      in1_data_wr = wr; in1_data = d; in1_data_valid_wr = vwr; in1_data_valid = vld;
    end
  endtask

  // Drives one packet; valid_wr rides on the tail word unless sep_vwr.
  task automatic send_pkt(input int port, input int len, input logic valid,
                          input logic sep_vwr, input logic push_exp, output int vwr_cyc);
    logic [133:0] w;
    logic last;
    vwr_cyc = -1;
    for (int k = 0; k < len; k++) begin
      last = (k == len - 1);
      w = make_word(k == 0 ? 2'b01 : (last ? 2'b10 : 2'b11));
      drive(port, 1'b1, w, last && !sep_vwr, valid);
      if (push_exp) exp_q.push_back({last, w});
      if (last && !sep_vwr) vwr_cyc = cyc;
      tick(1);
    end
    idle_inputs();
    if (sep_vwr) begin
      drive(port, 1'b0, '0, 1'b1, valid);
      vwr_cyc = cyc;
      tick(1);
      idle_inputs();
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_val(name, exp_q.size(), 0);
    tick(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(2);
    check_val("rst_out_wr", int'(out_data_wr), 0);
    check_val("rst_out_vwr", int'(out_data_valid_wr), 0);
    check_val("rst_ready0", int'(out_in0_ready), 0);
    exp_q.delete();
    rst_n = 1'b1;
    tick(1);
    check_val("rst_ready0_rel", int'(out_in0_ready), 1);
    check_val("rst_ready1_rel", int'(out_in1_ready), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int   port;
    int   len;
    logic valid;
    logic sep_vwr;
    int   exp_words;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t;
    int base;
    int k0;
    logic [133:0] w;

    vecs[0] = '{0, 4, 1'b1, 1'b0, 4};
    vecs[1] = '{1, 1, 1'b1, 1'b0, 1};
    vecs[2] = '{1, 3, 1'b0, 1'b0, 0};
    vecs[3] = '{1, 5, 1'b1, 1'b1, 5};
    vecs[4] = '{0, 2, 1'b0, 1'b1, 0};
    vecs[5] = '{0, 7, 1'b1, 1'b1, 7};
    vecs[6] = '{1, 96, 1'b1, 1'b0, 96};
    vecs[7] = '{0, 6, 1'b1, 1'b0, 6};

    rst_n = 1'b0;
    in_port_usedw = 8'd0;
    idle_inputs();
    do_reset();

    // Single 4-word packet: first word at T+2, tail at T+5.
    first_cyc = -1;
    send_pkt(0, 4, 1'b1, 1'b0, 1'b1, t);
    wait_drain("t1_drain", 40);
    check_val("t1_first_cyc", first_cyc, t + 2);
    check_val("t1_last_cyc", last_cyc, t + 5);

    // Table: one packet at a time, count emitted words.
    foreach (vecs[v]) begin
      base = out_cnt;
      send_pkt(vecs[v].port, vecs[v].len, vecs[v].valid, vecs[v].sep_vwr,
               vecs[v].valid, t);
      wait_drain($sformatf("vec%0d_drain", v), 300);
      check_val($sformatf("vec%0d_words", v), out_cnt - base, vecs[v].exp_words);
      check_val($sformatf("vec%0d_ready", v),
                int'(vecs[v].port == 0 ? out_in0_ready : out_in1_ready), 1);
    end

    // Round robin: three packets each, queued while blocked.
    do_reset();
    in_port_usedw = 8'd255;
    base = out_cnt;
    send_pkt(0, 3, 1'b1, 1'b0, 1'b1, t);
    send_pkt(1, 5, 1'b1, 1'b0, 1'b1, t);
    send_pkt(0, 2, 1'b1, 1'b1, 1'b1, t);
    send_pkt(1, 4, 1'b1, 1'b0, 1'b1, t);
    send_pkt(0, 6, 1'b1, 1'b0, 1'b1, t);
    send_pkt(1, 1, 1'b1, 1'b0, 1'b1, t);
    tick(5);
    check_val("t2_blocked", out_cnt - base, 0);
    in_port_usedw = 8'd0;
    wait_drain("t2_drain", 100);
    check_val("t2_words", out_cnt - base, 21);

    // Back-pressure at packet start only.
    do_reset();
    in_port_usedw = 8'd200;
    base = out_cnt;
    send_pkt(0, 4, 1'b1, 1'b0, 1'b1, t);
    tick(10);
    check_val("t3_held", out_cnt - base, 0);
    first_cyc = -1;
    in_port_usedw = 8'd160;
    k0 = cyc;
    tick(1);
    in_port_usedw = 8'd255;
    tick(8);
    check_val("t3_start_cyc", first_cyc, k0 + 1);
    check_val("t3_words", out_cnt - base, 4);
    in_port_usedw = 8'd0;

    // Second head before valid_wr: abandoned packet vanishes.
    base = out_cnt;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, make_word(k == 0 ? 2'b01 : 2'b11), 1'b0, 1'b0);
      tick(1);
    end
    send_pkt(0, 3, 1'b1, 1'b0, 1'b1, t);
    wait_drain("abandon_drain", 40);
    check_val("abandon_words", out_cnt - base, 3);

    // Overflow: 300 words ignoring ready.
    do_reset();
    base = out_cnt;
    for (int k = 0; k < 300; k++) begin
      w = make_word(k == 0 ? 2'b01 : (k == 299 ? 2'b10 : 2'b11));
      drive(0, 1'b1, w, k == 299, 1'b1);
      tick(1);
      if (k == 149) check_val("t5_ready_150", int'(out_in0_ready), 1);
      if (k == 169) check_val("t5_ready_170", int'(out_in0_ready), 0);
    end
    idle_inputs();
    tick(300);
    check_val("t5_dropped", out_cnt - base, 0);
    check_val("t5_ready_after", int'(out_in0_ready), 1);
    send_pkt(0, 5, 1'b1, 1'b0, 1'b1, t);
    send_pkt(0, 3, 1'b1, 1'b1, 1'b1, t);
    wait_drain("t5_drain", 60);
    check_val("t5_words", out_cnt - base, 8);

    // Reset in the middle of a SEND.
    do_reset();
    base = out_cnt;
    send_pkt(0, 8, 1'b1, 1'b0, 1'b1, t);
    for (int n = 0; n < 20 && (out_cnt - base) < 3; n++) tick(1);
    check_val("t6_reached_send", int'((out_cnt - base) >= 3), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_wr", int'(out_data_wr), 0);
    check_val("t6_rst_data_zero", int'(out_data == '0), 1);
    check_val("t6_rst_valid", int'(out_data_valid | out_data_valid_wr), 0);
    exp_q.delete();
    do_reset();
    base = out_cnt;
    drive(0, 1'b1, make_word(2'b11), 1'b0, 1'b1);
    tick(1);
    drive(0, 1'b1, make_word(2'b10), 1'b1, 1'b1);
    tick(1);
    idle_inputs();
    tick(10);
    check_val("t6_orphans", out_cnt - base, 0);
    send_pkt(0, 3, 1'b1, 1'b0, 1'b1, t);
    wait_drain("t6_drain", 40);
    check_val("t6_words", out_cnt - base, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
